// File: rtl/mips_lsu.sv
// MIPS load/store unit: one access at a time between the CPU and a
// single-cycle-latency data RAM, with lane steering and load extension.
module mips_lsu #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [3:0]  byteenable,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_write;
  logic        r_uns;

  logic        w_accept;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [1:0]  w_lane_a;
  logic [1:0]  w_lane_b;
  logic [7:0]  w_byte_a;
  logic [7:0]  w_byte_b;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // Byte offset to physical lane.
  function automatic logic [1:0] f_lane(input logic [1:0] off);
    return BIG_ENDIAN ? ~off : off;
  endfunction

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;

  // Alignment and size check on the live request.
  always_comb begin
    w_err = 1'b0;
    unique case (req_size)
      2'b00: w_err = 1'b0;
      2'b01: w_err = req_addr[0];
      2'b10: w_err = (req_addr[1:0] != 2'b00);
      2'b11: w_err = 1'b1;
    endcase
  end

  // Store lane enables and replicated write data.
  always_comb begin
    w_be = 4'b1111;
    w_wd = req_wdata;
    unique case (req_size)
      2'b00: begin
        w_be = 4'b0001 << f_lane(req_addr[1:0]);
        w_wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be = (4'b0001 << f_lane({req_addr[1], 1'b0}))
             | (4'b0001 << f_lane({req_addr[1], 1'b1}));
        w_wd = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = req_wdata;
      end
    endcase
  end

  // Lane a holds the addressed (lower-offset) byte, lane b the next one.
  assign w_lane_a = r_size[0] ? f_lane({r_off[1], 1'b0}) : f_lane(r_off);
  assign w_lane_b = f_lane({r_off[1], 1'b1});
  assign w_byte_a = data_readdata[{w_lane_a, 3'b000} +: 8];
  assign w_byte_b = data_readdata[{w_lane_b, 3'b000} +: 8];
  assign w_half   = BIG_ENDIAN ? {w_byte_a, w_byte_b} : {w_byte_b, w_byte_a};

  // Load extraction with sign or zero extension.
  always_comb begin
    w_load = data_readdata;
    unique case (r_size)
      2'b00: w_load = r_uns ? {24'b0, w_byte_a}
                            : {{24{w_byte_a[7]}}, w_byte_a};
      2'b01: w_load = r_uns ? {16'b0, w_half}
                            : {{16{w_half[15]}}, w_half};
      default: w_load = data_readdata;
    endcase
  end

  // Access sequencer and all registered RAM/response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_off          <= 2'b00;
      r_size         <= 2'b00;
      r_write        <= 1'b0;
      r_uns          <= 1'b0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= 32'b0;
      data_address   <= 32'b0;
      data_read      <= 1'b0;
      data_write     <= 1'b0;
      byteenable     <= 4'b0000;
      data_writedata <= 32'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off   <= req_addr[1:0];
            r_size  <= req_size;
            r_write <= req_write;
            r_uns   <= req_unsigned;
            if (w_err) begin
              r_state    <= S_DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'b0;
            end else begin
              r_state      <= S_ISSUE;
              data_address <= {req_addr[31:2], 2'b00};
              if (req_write) begin
                data_write     <= 1'b1;
                byteenable     <= w_be;
                data_writedata <= w_wd;
              end else begin
                data_read <= 1'b1;
              end
            end
          end
        end
        S_ISSUE: begin
          data_read  <= 1'b0;
          data_write <= 1'b0;
          byteenable <= 4'b0000;
          if (r_write) begin
            r_state    <= S_DONE;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= 32'b0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state    <= S_DONE;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= w_load;
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 Parameter: BIG_ENDIAN, 0, byte-lane order (0: byte offset k uses lane k; 1: byte offset k uses lane 3-k; lane n = bits 8n+7:8n).
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-006 req_write  input  1  1 store, 0 load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  loads only: 1 zero-extend, 0 sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-013 resp_error  output  1  qualified by resp_valid; misaligned or illegal size.
REQ-014 data_address  output  32  {addr[31:2],2'b00} to data RAM.
REQ-015 data_read  output  1  RAM read strobe.
REQ-016 data_write  output  1  RAM write strobe.
REQ-017 byteenable  output  4  RAM write lane enables.
REQ-018 data_writedata  output  32  lane-replicated store data.
REQ-019 data_readdata  input  32  RAM read word, valid the cycle after data_read is sampled.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, DONE; state, request fields and all outputs except req_ready are registered.
REQ-021 On acceptance, the block captures addr, size, write, unsigned and wdata; later changes to the req_* inputs are ignored until the next acceptance.
REQ-022 Error check on acceptance: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> DONE next cycle, resp_error=1, no RAM strobe ever asserted.
REQ-023 Legal load: IDLE->ISSUE (data_read=1 exactly one cycle) ->WAIT (capture data_readdata at end of cycle) ->DONE; resp_valid 3 cycles after acceptance.
REQ-024 Legal store: IDLE->ISSUE (data_write=1 exactly one cycle, byteenable valid) ->DONE; resp_valid 2 cycles after acceptance.
REQ-025 DONE lasts exactly one cycle, then IDLE; no new request is accepted in DONE.
REQ-026 data_read and data_write are never both 1; byteenable=0000 whenever data_write=0.
REQ-027 Byteenable: byte -> one lane per BIG_ENDIAN mapping of addr[1:0]; half -> lanes for offsets addr[1] and addr[1]+1; word -> 1111.
REQ-028 data_writedata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-029 Load extract: select the byte/half from the addressed lane(s) (half: lower-offset byte is LSB when BIG_ENDIAN=0, MSB when 1); sign- or zero-extend to 32 per req_unsigned; word passes through.
REQ-030 req_unsigned is ignored for word loads and for stores.
REQ-031 resp_rdata holds its value until the next resp_valid; data_address holds its last value when idle.

Reset
REQ-032 Reset asserted in any state -> IDLE immediately; data_read, data_write, resp_valid, resp_error = 0; byteenable=0000; resp_rdata, data_address, data_writedata = 0.
REQ-033 An in-flight request at reset is dropped with no response; the first request after deassertion is accepted in the first clock with req_valid=1.

Verification
REQ-034 LW addr 0xBFC00010, RAM word 0x8899AABB -> data_read=1 cycle 1 with data_address 0xBFC00010; resp_valid cycle 3, rdata 0x8899AABB, error 0.
REQ-035 LB/LBU addr 0xBFC00013, word 0x8899AABB, BIG_ENDIAN=0 -> LB rdata 0xFFFFFF88; LBU 0x00000088; BIG_ENDIAN=1 LB -> 0xFFFFFFBB.
REQ-036 SH addr 0xBFC00002 wdata 0x1234ABCD, BIG_ENDIAN=0 -> data_write 1 cycle, byteenable 1100, data_writedata 0xABCDABCD; resp_valid cycle 2.
REQ-037 LW addr 0xBFC00001, and any req_size=11 -> resp_valid next cycle, resp_error=1, data_read/data_write never asserted.
REQ-038 Reset asserted during WAIT of a load -> strobes 0 and no resp_valid; LW issued after release completes normally in 3 cycles.
REQ-039 Back-to-back req_valid held high over 3 stores -> req_ready low ISSUE..DONE; exactly one data_write pulse per store; acceptances 3 cycles apart.
